// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision constants and types for the FP/integer
// conversion path and the FP ALU exception logic.
package fp32_pkg;

  localparam int FP_BIAS = 127;
  localparam int EXP_W   = 8;
  localparam int MANT_W  = 23;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH,
    DONE
  } state_t;

endpackage

// File: rtl/fp32_to_int32_seq_if.sv
// Valid/ready operand and result bus of the float-to-int32 converter.
// The converter is the slave; the producer/consumer side is the master.
interface fp32_to_int32_seq_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_overflow;
  logic        out_invalid;
  logic        out_inexact;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_overflow, out_invalid, out_inexact
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, out_invalid, out_inexact
  );

endinterface

// File: rtl/fp32_classify.sv
// Combinational float classifier: special encodings, range buckets relative
// to int32, and the unbiased exponent. Shared with the FP ALU exception logic.
module fp32_classify
  import fp32_pkg::*;
(
  input  fp32_t             f,
  output logic              is_nan,
  output logic              is_inf,
  output logic              is_zero,
  output logic              is_small,
  output logic              is_big,
  output logic signed [8:0] exp_unb
);

  logic exp_max;
  logic mant_zero;

  assign exp_max   = (f.exp == '1);
  assign mant_zero = (f.mant == '0);

  assign is_nan   = exp_max && !mant_zero;
  assign is_inf   = exp_max && mant_zero;
  assign is_zero  = (f.exp == '0) && mant_zero;
  // |x| < 1, including zero and denormals
  assign is_small = (f.exp < 8'(FP_BIAS));
  // |x| >= 2^31 but finite
  assign is_big   = (f.exp >= 8'(FP_BIAS + 31)) && !exp_max;
  assign exp_unb  = $signed({1'b0, f.exp} - 9'(FP_BIAS));

endmodule

// File: rtl/fp32_to_int32_seq.sv
// Multi-cycle IEEE-754 single to int32 converter with an iterative aligner.
// Define FP2INT_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
module fp32_to_int32_seq
  import fp32_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  fp32_to_int32_seq_if.slave  bus
);

  if (SHIFT_STEP != 1 && SHIFT_STEP != 2 && SHIFT_STEP != 4 && SHIFT_STEP != 8) begin : g_bad_step
    $error("fp32_to_int32_seq: SHIFT_STEP must be 1, 2, 4 or 8");
  end

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  fp32_t             op;
  logic              is_nan, is_inf, is_zero, is_small, is_big;
  logic signed [8:0] exp_unb;

  assign op = fp32_t'(bus.in_data);

  fp32_classify u_classify (
    .f        (op),
    .is_nan   (is_nan),
    .is_inf   (is_inf),
    .is_zero  (is_zero),
    .is_small (is_small),
    .is_big   (is_big),
    .exp_unb  (exp_unb)
  );

  state_t      state;
  logic        sign;
  logic [31:0] mag;
  logic [4:0]  cnt;
  logic        dir_left;
  logic        guard;
  logic        sticky;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] out_data_q;
  logic        ovf_q, inv_q, inex_q;

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_overflow = ovf_q;
  assign bus.out_invalid  = inv_q;
  assign bus.out_inexact  = inex_q;

  logic [4:0]  cnt_init;
  logic        left_init;
  logic [4:0]  amt;
  logic [31:0] lost_mask;
  logic [31:0] rounded;
  logic        round_inc;
  logic [31:0] fin_data;
  logic        fin_ovf;
  logic [31:0] small_data;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    left_init = (exp_unb > 9'sd23);
    cnt_init  = left_init ? 5'(exp_unb - 9'sd23) : 5'(9'sd23 - exp_unb);

    amt       = (cnt < STEP) ? cnt : STEP;
    // Bits below the new guard position that fall off this cycle
    lost_mask = (32'd1 << (amt - 5'd1)) - 32'd1;

`ifdef FP2INT_ROUND_NEAREST_EN
    round_inc  = guard && (sticky || mag[0]);
    small_data = (op.exp == 8'(FP_BIAS - 1) && op.mant != '0)
                 ? (op.sign ? 32'hFFFF_FFFF : 32'd1) : 32'd0;
`else
    round_inc  = 1'b0;
    small_data = 32'd0;
`endif
    rounded = mag + 32'(round_inc);

    fin_ovf  = 1'b0;
    fin_data = sign ? (~rounded + 32'd1) : rounded;
    if (rounded[31]) begin
      // Rounding carried into 2^31: only -2^31 is representable
      fin_data = sign ? INT32_MIN : INT32_MAX;
      fin_ovf  = !sign || (rounded != INT32_MIN);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sign        <= 1'b0;
      mag         <= '0;
      cnt         <= '0;
      dir_left    <= 1'b0;
      guard       <= 1'b0;
      sticky      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
      inv_q       <= 1'b0;
      inex_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            sign       <= op.sign;
            mag        <= {8'b0, 1'b1, op.mant};
            guard      <= 1'b0;
            sticky     <= 1'b0;
            ovf_q      <= 1'b0;
            inv_q      <= 1'b0;
            inex_q     <= 1'b0;
            if (is_nan) begin
              out_data_q  <= INT32_MAX;
              inv_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else if (is_inf) begin
              out_data_q  <= op.sign ? INT32_MIN : INT32_MAX;
              ovf_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else if (is_small) begin
              out_data_q  <= small_data;
              inex_q      <= !is_zero;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else if (is_big) begin
              out_data_q  <= op.sign ? INT32_MIN : INT32_MAX;
              ovf_q       <= (bus.in_data != 32'hCF00_0000);
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              cnt      <= cnt_init;
              dir_left <= left_init;
              state    <= (cnt_init == '0) ? FINISH : SHIFT;
            end
          end
        end

        SHIFT: begin
          if (dir_left) begin
            mag <= mag << amt;
          end else begin
            mag    <= mag >> amt;
            guard  <= mag[amt - 5'd1];
            sticky <= sticky || guard || (|(mag & lost_mask));
          end
          cnt <= cnt - amt;
          if (cnt == amt) state <= FINISH;
        end

        FINISH: begin
          out_data_q  <= fin_data;
          ovf_q       <= fin_ovf;
          inv_q       <= 1'b0;
          inex_q      <= guard || sticky;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_to_int32_seq.sv
// Directed-vector bench for fp32_to_int32_seq: one SHIFT_STEP=1 and one
// SHIFT_STEP=8 instance, expectations hand-computed per operand.
module tb_fp32_to_int32_seq;

`ifdef FP2INT_ROUND_NEAREST_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fp32_to_int32_seq_if bus ();
  fp32_to_int32_seq_if bus8 ();

  fp32_to_int32_seq #(.SHIFT_STEP(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  fp32_to_int32_seq #(.SHIFT_STEP(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags(input bit use8);
    if (use8) return 32'({bus8.out_overflow, bus8.out_invalid, bus8.out_inexact});
    return 32'({bus.out_overflow, bus.out_invalid, bus.out_inexact});
  endfunction

  // Issue one operand at #1 after a posedge, wait for out_valid, check, accept.
  // e_flags = {overflow, invalid, inexact}; e_lat <= 0 skips the latency check.
  task automatic run_op(input string tag, input bit use8, input logic [31:0] val,
                        input logic [31:0] e_data, input logic [2:0] e_flags, input int e_lat);
    int lat;
    bit seen;
    check({tag, "_rdy"}, 32'(use8 ? bus8.in_ready : bus.in_ready), 32'd1);
    if (use8) begin bus8.in_valid = 1'b1; bus8.in_data = val; end
    else      begin bus.in_valid  = 1'b1; bus.in_data  = val; end
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus.in_valid  = 1'b0;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (use8 ? bus8.out_valid : bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_valid"}, 32'(seen), 32'd1);
    if (e_lat > 0) check({tag, "_lat"}, 32'(lat), 32'(e_lat));
    check({tag, "_data"}, use8 ? bus8.out_data : bus.out_data, e_data);
    check({tag, "_flags"}, flags(use8), 32'(e_flags));
    if (use8) bus8.out_ready = 1'b1; else bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    bus.out_ready  = 1'b0;
    check({tag, "_idle"}, 32'(use8 ? bus8.out_valid : bus.out_valid), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.in_data   = '0;
    bus8.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_flags", flags(1'b0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal path: right shifts, exact alignment, left shifts
    run_op("one",       1'b0, 32'h3F80_0000, 32'd1,         3'b000, 25);
    run_op("one_s8",    1'b1, 32'h3F80_0000, 32'd1,         3'b000, 5);
    run_op("m123_45",   1'b0, 32'hC2F6_E666, 32'hFFFF_FF85, 3'b001, 19);
    run_op("two23",     1'b0, 32'h4B00_0000, 32'h0080_0000, 3'b000, 2);
    run_op("two30",     1'b0, 32'h4E80_0000, 32'h4000_0000, 3'b000, 9);
    run_op("m_two30",   1'b0, 32'hCE80_0000, 32'hC000_0000, 3'b000, 9);
    run_op("ten_s8",    1'b1, 32'h4120_0000, 32'd10,        3'b000, 5);

    // Saturation and specials
    run_op("two31",     1'b0, 32'h4F00_0000, 32'h7FFF_FFFF, 3'b100, 1);
    run_op("m_two31",   1'b0, 32'hCF00_0000, 32'h8000_0000, 3'b000, 1);
    run_op("m_big",     1'b0, 32'hCF00_0001, 32'h8000_0000, 3'b100, 1);
    run_op("nan",       1'b0, 32'h7FC0_0000, 32'h7FFF_FFFF, 3'b010, 1);
    run_op("m_inf",     1'b0, 32'hFF80_0000, 32'h8000_0000, 3'b100, 1);
    run_op("p_inf",     1'b0, 32'h7F80_0000, 32'h7FFF_FFFF, 3'b100, 1);

    // Rounding-sensitive values and |x| < 1
    run_op("one_5",     1'b0, 32'h3FC0_0000, RNE ? 32'd2 : 32'd1, 3'b001, 25);
    run_op("two_5",     1'b0, 32'h4020_0000, 32'd2,         3'b001, 24);
    run_op("half",      1'b0, 32'h3F00_0000, 32'd0,         3'b001, 1);
    run_op("p0_75",     1'b0, 32'h3F40_0000, RNE ? 32'd1 : 32'd0, 3'b001, 1);
    run_op("m0_75",     1'b0, 32'hBF40_0000, RNE ? 32'hFFFF_FFFF : 32'd0, 3'b001, 1);
    run_op("zero",      1'b0, 32'h0000_0000, 32'd0,         3'b000, 1);
    run_op("m_zero",    1'b0, 32'h8000_0000, 32'd0,         3'b000, 1);
    run_op("denorm",    1'b0, 32'h0000_0001, 32'd0,         3'b001, 1);

    // Backpressure: result held six cycles, pending operand ignored
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h4120_0000;
    @(posedge clk); #1;
    bus.in_data = 32'h3F80_0000;
    for (int i = 0; i < 40 && !bus.out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_hold%0d_data", i), bus.out_data, 32'd10);
      check($sformatf("bp_hold%0d_flags", i), flags(1'b0), 32'd0);
      check($sformatf("bp_hold%0d_rdy", i), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_release", 32'(bus.out_valid), 32'd0);
    check("bp_in_ready", 32'(bus.in_ready), 32'd1);

    // Reset during SHIFT aborts the conversion
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h3F80_0000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_data", bus.out_data, 32'd0);
    run_op("after_rst", 1'b0, 32'h4120_0000, 32'd10, 3'b000, 22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
